// File: rtl/lookup_result_fifo_pkg.sv
// Shared constants and bit layouts for the lookup-stage result FIFO interface.
// The lookup stage packs its result words with these structs, so both sides agree on field positions.
package lookup_result_fifo_pkg;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;
    localparam int PTR_W  = 2;

    typedef struct packed {
        logic              out_ready;
        logic              in_valid;
        logic [DATA_W-1:0] in_data;
    } FifoIn;

    typedef struct packed {
        logic [CNT_W-1:0]  count;
        logic              in_ready;
        logic              out_valid;
        logic [DATA_W-1:0] out_data;
    } FifoOut;

endpackage

// File: rtl/lookup_result_fifo_wrap_counter.sv
// Pointer counter: advances on inc_i and wraps naturally at 2^W, with a synchronous clear.
// Latency 1 (registered count); no backpressure, it steps whenever inc_i is high.
module wrap_counter #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/lookup_result_fifo.sv
// 4-entry result FIFO behind the table lookup; first-word latency 1, no fall-through.
// in_ready drops at count 4 and only recovers on the edge after a pop; outputs come from registered state only.
module lookup_result_fifo
    import lookup_result_fifo_pkg::*;
(
    input  logic [1:0] arg_0,
    input  logic [5:0] arg_1,
    output logic [8:0] out
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic clk;
    logic rst;
    assign clk = arg_0[0];
    assign rst = arg_0[1];

    FifoIn  in_s;
    FifoOut out_s;
    assign in_s = arg_1;
    assign out  = out_s;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              in_rdy;
    logic              out_vld;
    logic              push;
    logic              pop;

    always_comb begin
        in_rdy  = (count_q != FULL_CNT);
        out_vld = (count_q != '0);
        push    = in_s.in_valid & in_rdy;
        pop     = out_vld & in_s.out_ready;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        // Gate the head so an empty FIFO presents zeros rather than stale data.
        out_s.count     = count_q;
        out_s.in_ready  = in_rdy;
        out_s.out_valid = out_vld;
        out_s.out_data  = out_vld ? mem_q[rd_ptr] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (push) begin
                mem_q[wr_ptr] <= in_s.in_data;
            end
        end
    end

    wrap_counter #(.W(PTR_W)) u_wr_ptr (
        .clk_i (clk),
        .clr_i (rst),
        .inc_i (push),
        .cnt_o (wr_ptr)
    );

    wrap_counter #(.W(PTR_W)) u_rd_ptr (
        .clk_i (clk),
        .clr_i (rst),
        .inc_i (pop),
        .cnt_o (rd_ptr)
    );

endmodule
